alu_seq: RTL
============

# alu_seq

Sequential 8-bit-default ALU that produces the result and the Z/N/V/C flag values that feed the CPU's flag status register. Single-cycle operations (add, subtract, logic, shifts) complete in one clock. Unsigned multiply runs as an iterative shift-add over WIDTH clocks behind a start/busy/done handshake. Flag outputs connect directly to the status register's Z_in/N_in/V_in/C_in and are qualified by `done`.

## Interface

- WIDTH, 8, operand and result width in bits (≥ 2)

- clk  input  1  system clock; all state updates on rising edge
- rst_n  input  1  synchronous, active-low reset, sampled on rising edge of clk
- start  input  1  request; sampled only while busy=0
- op  input  3  operation code, sampled with start
- a  input  WIDTH  operand A, sampled with start
- b  input  WIDTH  operand B, sampled with start (ignored for SHL/SHR)
- busy  output  1  high while a multiply is iterating
- done  output  1  one-cycle pulse: result and flags updated
- result  output  WIDTH  registered result
- Z_out, N_out, V_out, C_out  output  1 each  registered flags

## Operation

- Opcodes: 000 ADD a+b; 001 SUB a−b; 010 AND; 011 OR; 100 XOR; 101 SHL a<<1; 110 SHR a>>1 logical; 111 MUL a×b unsigned, low WIDTH bits to result.
- Z = (result == 0); N = result[WIDTH−1], for every op.
- ADD: C = carry out of bit WIDTH−1; V = signed overflow (operand signs equal, result sign differs).
- SUB: C = borrow (1 when a < b unsigned); V = signed overflow (operand signs differ, result sign differs from a).
- AND/OR/XOR: C = 0, V = 0.
- SHL: C = a[WIDTH−1], V = 0. SHR: C = a[0], V = 0.
- MUL: C = V = 1 when the upper WIDTH bits of the 2·WIDTH product are nonzero.
- FSM states:
  - IDLE: busy=0. start with op≠111 → compute, register result and flags, pulse done, stay IDLE. start with op=111 → latch a as multiplicand (zero-extended to 2·WIDTH), latch b as multiplier, clear accumulator and iteration counter, go to MUL.
  - MUL: busy=1. Each clock: if multiplier[0] then accumulator += multiplicand. Multiplicand shifts left 1, multiplier shifts right 1, counter increments. After iteration WIDTH, register result and flags from the final product, pulse done, return to IDLE.
- start is ignored while busy=1; no queuing.
- result and flags hold their values between done pulses; they change only on a done-producing edge.
- Reset (rst_n=0 at a rising edge): state IDLE, busy=0, done=0, result=0, Z_out=N_out=V_out=C_out=0, accumulator and counter cleared. Reset during MUL aborts the operation with no done pulse. Reset has priority over start.

## Timing

- Non-MUL: start sampled at edge k. result, flags and done are valid in cycle k+1. done falls at edge k+1 unless a new start is accepted at that edge. Back-to-back single-cycle ops at one per clock are supported, with done held high continuously.
- MUL: start sampled at edge k. busy is high in cycles k+1 … k+WIDTH. At edge k+WIDTH busy falls, done rises, and result/flags update. A new start is accepted at edge k+WIDTH+1 at the earliest.
- The downstream status register samples flags on every clock. The flags are meaningful at the edge where done is high.
- No combinational path from any input to any output.

## Test plan

- Reset then ADD a=0x7F b=0x01 → one cycle later: done=1, result=0x80, Z=0 N=1 V=1 C=0. Next cycle: done=0, and outputs hold.
- SUB a=0x05 b=0x05 → 0x00, Z=1 N=0 V=0 C=0. Then SUB a=0x00 b=0x01 → 0xFF, Z=0 N=1 V=0 C=1. Issue both back-to-back: done stays high for 2 cycles.
- MUL a=13 b=11 → busy for 8 cycles. Done at the 8th edge after start with result=0x8F, N=1 C=0 V=0. A start pulse with op=ADD during busy is ignored: no extra done, and result is unchanged.
- MUL a=0x10 b=0x10 → result=0x00, Z=1 N=0 C=1 V=1.
- SHL a=0x81 → 0x02, C=1. SHR a=0x01 → 0x00, Z=1 C=1 V=0. Verify b is ignored by driving b=0xFF.
- MUL started, rst_n=0 at iteration 4 → next cycle busy=0, done=0, result and all flags 0, and no later done appears. Release reset, then ADD 0x01+0x01 → result 0x02 one cycle after start.

Source files
------------

// File: rtl/alu_seq_if.sv
// Handshake and data bundle between a requester and alu_seq.
// Master issues operations; slave returns result and flags.
interface alu_seq_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             Z_out;
  logic             N_out;
  logic             V_out;
  logic             C_out;

  modport master (
    output start, op, a, b,
    input  busy, done, result,
    input  Z_out, N_out, V_out, C_out
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result,
    output Z_out, N_out, V_out, C_out
  );
endinterface

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle add/sub/logic/shift,
// iterative shift-add unsigned multiply over WIDTH clocks.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input logic     clk,
  input logic     rst_n,
  alu_seq_if.slave bus
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic {
    IDLE,
    MUL
  } state_t;

  state_t state, state_n;

  logic [2*WIDTH-1:0] mcand, acc, acc_nx;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;
  logic               last;

  logic [WIDTH-1:0]   res_q;
  logic               z_q, n_q, v_q, c_q, done_q;

  logic [WIDTH:0]     sum, diff;
  logic [WIDTH-1:0]   s_res;
  logic               s_c, s_v;
  logic               accept, mul_go;

  assign accept = (state == IDLE) && bus.start;
  assign mul_go = accept && (bus.op == OP_MUL);
  assign last   = (cnt == CW'(WIDTH - 1));
  assign acc_nx = acc + (mplier[0] ? mcand : '0);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // Next-state: enter MUL on a multiply start, leave after last step
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (mul_go) state_n = MUL;
      MUL:     if (last)   state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Single-cycle result and carry/overflow
  always_comb begin
    sum   = {1'b0, bus.a} + {1'b0, bus.b};
    diff  = {1'b0, bus.a} - {1'b0, bus.b};
    s_res = '0;
    s_c   = 1'b0;
    s_v   = 1'b0;
    unique case (bus.op)
      OP_ADD: begin
        s_res = sum[WIDTH-1:0];
        s_c   = sum[WIDTH];
        s_v   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) &&
                (sum[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_SUB: begin
        s_res = diff[WIDTH-1:0];
        s_c   = diff[WIDTH];
        s_v   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) &&
                (diff[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_AND: s_res = bus.a & bus.b;
      OP_OR:  s_res = bus.a | bus.b;
      OP_XOR: s_res = bus.a ^ bus.b;
      OP_SHL: begin
        s_res = {bus.a[WIDTH-2:0], 1'b0};
        s_c   = bus.a[WIDTH-1];
      end
      OP_SHR: begin
        s_res = {1'b0, bus.a[WIDTH-1:1]};
        s_c   = bus.a[0];
      end
      OP_MUL: s_res = '0;
      default: s_res = '0;
    endcase
  end

  // Datapath: multiply iteration and result/flag registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      res_q  <= '0;
      z_q    <= 1'b0;
      n_q    <= 1'b0;
      v_q    <= 1'b0;
      c_q    <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state == IDLE) begin
        if (mul_go) begin
          mcand  <= {{WIDTH{1'b0}}, bus.a};
          mplier <= bus.b;
          acc    <= '0;
          cnt    <= '0;
        end else if (accept) begin
          res_q  <= s_res;
          z_q    <= (s_res == '0);
          n_q    <= s_res[WIDTH-1];
          v_q    <= s_v;
          c_q    <= s_c;
          done_q <= 1'b1;
        end
      end else begin
        acc    <= acc_nx;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + CW'(1);
        if (last) begin
          res_q  <= acc_nx[WIDTH-1:0];
          z_q    <= (acc_nx[WIDTH-1:0] == '0);
          n_q    <= acc_nx[WIDTH-1];
          v_q    <= |acc_nx[2*WIDTH-1:WIDTH];
          c_q    <= |acc_nx[2*WIDTH-1:WIDTH];
          done_q <= 1'b1;
        end
      end
    end
  end

  assign bus.busy   = (state == MUL);
  assign bus.done   = done_q;
  assign bus.result = res_q;
  assign bus.Z_out  = z_q;
  assign bus.N_out  = n_q;
  assign bus.V_out  = v_q;
  assign bus.C_out  = c_q;

endmodule
